control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_pkg.sv | 66 ++++++
 rtl/imm_gen.sv | 35 +++
 rtl/control_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/control_pkg.sv
// control_pkg
// Shared decode constants and state encoding for the RV64 subset control unit
// (ld, sd, addi, add, sub). The datapath top level imports the same package.
//   - Opcode / funct3 / funct7 constants
//   - state_t      : FSM state encoding
//   - instrKind_t  : decoded instruction class
//   - decodeKind() : classifies an instruction word into instrKind_t
package control_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_OPIMM = 7'b0010011;
    localparam logic [6:0] OP_OP    = 7'b0110011;

    localparam logic [2:0] F3_LD    = 3'b011;
    localparam logic [2:0] F3_SD    = 3'b011;
    localparam logic [2:0] F3_ADDI  = 3'b000;
    localparam logic [2:0] F3_ADD   = 3'b000;

    localparam logic [6:0] F7_ADD   = 7'b0000000;
    localparam logic [6:0] F7_SUB   = 7'b0100000;

    // addi x0,x0,0 : the instruction register's reset contents
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        WRITEBACK = 3'd4,
        HALT      = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        INS_ILLEGAL = 3'd0,
        INS_LD      = 3'd1,
        INS_SD      = 3'd2,
        INS_ADDI    = 3'd3,
        INS_ADD     = 3'd4,
        INS_SUB     = 3'd5
    } instrKind_t;

    function automatic instrKind_t decodeKind(input logic [31:0] ir);
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        instrKind_t kind;
        opcode = ir[6:0];
        funct3 = ir[14:12];
        funct7 = ir[31:25];
        kind   = INS_ILLEGAL;
        if (opcode == OP_LOAD && funct3 == F3_LD)
            kind = INS_LD;
        else if (opcode == OP_STORE && funct3 == F3_SD)
            kind = INS_SD;
        else if (opcode == OP_OPIMM && funct3 == F3_ADDI)
            kind = INS_ADDI;
        else if (opcode == OP_OP && funct3 == F3_ADD && funct7 == F7_ADD)
            kind = INS_ADD;
        else if (opcode == OP_OP && funct3 == F3_ADD && funct7 == F7_SUB)
            kind = INS_SUB;
        return kind;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen
// Sign-extended immediate extraction from the instruction register.
// Ports:
//   ir        in  32  instruction register contents
//   immediate out 64  I-type / S-type immediate, sign-extended; 0 otherwise
module imm_gen
    import control_pkg::*;
(
    input  logic [31:0] ir,
    output logic [63:0] immediate
);

    logic signed [11:0] immI;
    logic signed [11:0] immS;
    logic signed [63:0] immExt;
    logic               unusedIrBits;

    assign immI = ir[31:20];
    assign immS = {ir[31:25], ir[11:7]};

    // rs1 and funct3 fields carry no immediate bits
    assign unusedIrBits = ^ir[19:12];

    always_comb begin
        immExt = '0;
        case (ir[6:0])
            OP_LOAD, OP_OPIMM: immExt = 64'(immI);
            OP_STORE:          immExt = 64'(immS);
            default:           immExt = '0;
        endcase
    end

    assign immediate = immExt;

endmodule

// File: rtl/control_unit.sv
// control_unit
// Multi-cycle FSM controller for an RV64 subset (ld, sd, addi, add, sub).
// Sequence: FETCH -> DECODE -> EXECUTE -> [MEMORY] -> [WRITEBACK] -> FETCH;
// an unsupported encoding parks the FSM in HALT until rst.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   instr_valid, instr       instruction handshake input (accepted in FETCH)
//   instr_ready              high only in FETCH
//   pc                       address of the current instruction
//   immediate                sign-extended immediate from IR
//   readRegister1/2          rs1 / rs2 addresses from IR
//   writeRegister            rd address from IR
//   writeEnable_DataMemory   one-cycle store strobe (MEMORY, sd)
//   writeEnable_Registers    one-cycle register write strobe (WRITEBACK, rd != 0)
//   muxSelect_SumVsReadData  write-back source: 1 adder, 0 memory
//   muxSelect_ImmVsDataout2  adder operand B: 1 immediate, 0 dataOut2
//   SumOrSub                 adder mode: 1 subtract
//   illegal                  sticky unsupported-instruction flag
module control_unit
    import control_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [63:0] pc,
    output logic [63:0] immediate,
    output logic [4:0]  readRegister1,
    output logic [4:0]  readRegister2,
    output logic [4:0]  writeRegister,
    output logic        writeEnable_DataMemory,
    output logic        writeEnable_Registers,
    output logic        muxSelect_SumVsReadData,
    output logic        muxSelect_ImmVsDataout2,
    output logic        SumOrSub,
    output logic        illegal
);

    state_t     state;
    state_t     nextState;
    logic [31:0] ir;
    instrKind_t kind;
    logic       pcAdvance;

    assign kind = decodeKind(ir);

    assign readRegister1 = ir[19:15];
    assign readRegister2 = ir[24:20];
    assign writeRegister = ir[11:7];

    assign muxSelect_ImmVsDataout2 = (kind == INS_LD) || (kind == INS_SD) || (kind == INS_ADDI);
    assign SumOrSub                = (kind == INS_SUB);
    assign muxSelect_SumVsReadData = (kind != INS_LD);

    imm_gen uImmGen (
        .ir        (ir),
        .immediate (immediate)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            ir      <= NOP_INSTR;
            pc      <= '0;
            illegal <= 1'b0;
        end else begin
            state <= nextState;
            if (state == FETCH && instr_valid)
                ir <= instr;
            if (state == DECODE && kind == INS_ILLEGAL)
                illegal <= 1'b1;
            if (pcAdvance)
                pc <= pc + 64'd4;
        end
    end

    // Strobes are gated by rst so a reset in MEMORY/WRITEBACK never lets a write escape.
    always_comb begin
        nextState              = state;
        instr_ready            = 1'b0;
        writeEnable_DataMemory = 1'b0;
        writeEnable_Registers  = 1'b0;
        pcAdvance              = 1'b0;
        case (state)
            FETCH: begin
                instr_ready = 1'b1;
                if (instr_valid)
                    nextState = DECODE;
            end
            DECODE: begin
                nextState = (kind == INS_ILLEGAL) ? HALT : EXECUTE;
            end
            EXECUTE: begin
                nextState = (kind == INS_LD || kind == INS_SD) ? MEMORY : WRITEBACK;
            end
            MEMORY: begin
                if (kind == INS_SD) begin
                    writeEnable_DataMemory = !rst;
                    nextState              = FETCH;
                    pcAdvance              = 1'b1;
                end else begin
                    nextState = WRITEBACK;
                end
            end
            WRITEBACK: begin
                writeEnable_Registers = !rst && (ir[11:7] != 5'd0);
                nextState             = FETCH;
                pcAdvance             = 1'b1;
            end
            HALT: begin
                nextState = HALT;
            end
            default: begin
                nextState = FETCH;
            end
        endcase
    end

endmodule
